spike_train_generator: RTL and testbench
========================================

// Module: spike_train_generator
// PURPOSE
//  Multi-channel, time-coded spike source for the SNN input layer.
//  - Owns the time-step counter; the per-neuron compare moves into this block.
//  - Per period, each of NUM_CH channels emits spikes from a latched spike time and enable.
//  - Two coding modes: LEVEL (spike while t < spike_time) and PULSE (one spike at t == spike_time).
//  - Feeds time_val and spikes to the downstream column/neuron array.
// PARAMETERS
//  NUM_CH      8                         number of spike channels
//  TIME_PERIOD `time_period              time steps per period (>=2)
//  TW          $clog2(TIME_PERIOD)       time field width (derived, do not override)
//  CW          $clog2(TIME_PERIOD+1)     spike-count width (derived, SPIKE_COUNT_EN only)
// PORTS
//  clk             in   1          clock, rising edge
//  rst             in   1          synchronous reset, active-high
//  load_valid      in   1          spike-time/enable vector offered
//  load_ready      out  1          block can accept a load
//  load_spike_time in   NUM_CH*TW  channel i at [i*TW +: TW]
//  load_en         in   NUM_CH     per-channel should_spike
//  mode            in   1          0 = LEVEL, 1 = PULSE; sampled on start
//  start           in   1          begin one period
//  busy            out  1          period in progress
//  time_val        out  TW         current time step
//  spikes          out  NUM_CH     spike vector for time_val
//  period_done     out  1          1-cycle pulse on the last step
//  spike_cnt       out  NUM_CH*CW  spikes emitted this period (SPIKE_COUNT_EN only)
// BEHAVIOUR
//  - Reset: state=IDLE; busy, spikes, period_done, time_val, spike_cnt all 0; load_ready=1.
//    Internal spike_time/en/mode registers cleared (all channels disabled).
//  - FSM IDLE -> RUN when start=1. RUN -> IDLE on the edge after time_val==TIME_PERIOD-1.
//    start is ignored in RUN.
//  - load_ready = (state==IDLE). Load accepted on load_valid&&load_ready; registers update that edge.
//    Load and start in the same IDLE cycle: the period uses the newly loaded values.
//  - mode is latched on the start edge and held for the whole period.
//  - RUN timing: first RUN cycle has time_val=0 and busy=1, so there is one cycle of latency from start.
//    time_val increments by 1 per cycle up to TIME_PERIOD-1, with no wrap inside a period.
//  - spikes is registered and aligned with time_val. Per channel i at time step t:
//    LEVEL: spikes[i] = en[i] && (spike_time[i] > t)  (unsigned compare)
//    PULSE: spikes[i] = en[i] && (spike_time[i] == t)
//    en[i]=0 forces 0.
//  - Compare edge cases:
//    LEVEL with spike_time=0: the channel never fires.
//    spike_time >= TIME_PERIOD (TIME_PERIOD not a power of 2): LEVEL fires every step, PULSE never fires.
//  - period_done=1 in the cycle time_val==TIME_PERIOD-1.
//  - Return to IDLE: next cycle busy=0, time_val=0, spikes=0.
//  - Back-to-back periods: start asserted in the first IDLE cycle after period_done gives one idle cycle between periods.
//  - rst asserted mid-period: abort at the next edge to the reset state; no period_done is emitted.
// CONFIGURATION
//  SPIKE_COUNT_EN defined:
//  - Per-channel CW-bit counter cleared on the start edge; +1 on each cycle its spike bit is 1.
//  - Value holds after the period until the next start or rst.
//  - Max count TIME_PERIOD, so no saturation is needed.
//  SPIKE_COUNT_EN undefined: the spike_cnt port and its counters do not exist.
// TESTING
//  (NUM_CH=4, TIME_PERIOD=8)
//  1. rst held 2 cycles mid-RUN -> next cycle busy=0, spikes=0, time_val=0, load_ready=1, no period_done.
//  2. LEVEL, times {5,0,7,3}, en=4'b1111 -> ch0 high t=0..4, ch1 never, ch2 t=0..6, ch3 t=0..2;
//     period_done at t=7.
//  3. PULSE, same times, en=4'b1011 -> ch0 at t=5, ch1 at t=0, ch2 silent, ch3 at t=3.
//  4. load_valid held during RUN -> load_ready=0, not accepted until IDLE.
//     Load+start same cycle -> new values used.
//  5. start in the cycle after period_done -> exactly one idle cycle, then time_val restarts at 0;
//     start during RUN ignored.
//  6. SPIKE_COUNT_EN, LEVEL times {5,0,7,3} -> spike_cnt {5,0,7,3}, held after the period, cleared on next start.

Source files
------------

// File: rtl/spike_train_generator.sv
// spike_train_generator
//   Multi-channel, time-coded spike source for the SNN input layer. It owns
//   the time-step counter and does the per-channel spike-time compare, so the
//   downstream column/neuron array only sees time_val and the spike vector.
//
//   A period is started from IDLE with start. For TIME_PERIOD cycles the block
//   steps time_val 0..TIME_PERIOD-1 and drives, per channel i:
//     LEVEL (mode=0): spikes[i] = en[i] && (spike_time[i] >  t)
//     PULSE (mode=1): spikes[i] = en[i] && (spike_time[i] == t)
//   spike_time/en are loaded only while idle; mode is latched on the start edge.
//
//   Optional build macro:
//     SPIKE_COUNT_EN  adds spike_cnt, a per-channel count of spikes emitted in
//                     the current/last period (cleared on start).
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   load_valid/ready  handshake for load_spike_time (NUM_CH*TW) and load_en
//   mode              0 = LEVEL, 1 = PULSE, sampled with start
//   start             begin one period (ignored while busy)
//   busy              period in progress
//   time_val          current time step
//   spikes            spike vector for time_val
//   period_done       one-cycle pulse on the last time step
//   spike_cnt         NUM_CH*CW spike counts (SPIKE_COUNT_EN only)

`ifndef STG_TIME_PERIOD
`define STG_TIME_PERIOD 8
`endif

// One channel's compare: combinational, evaluated on next-state values so the
// registered spike bit lines up with the registered time step.
module spike_train_generator_lane #(
  parameter int TW = 3
) (
  input  logic [TW-1:0] st_i,
  input  logic [TW-1:0] t_i,
  input  logic          en_i,
  input  logic          mode_i,
  output logic          spk_o
);
  assign spk_o = en_i && (mode_i ? (st_i == t_i) : (st_i > t_i));
endmodule

module spike_train_generator #(
  parameter int NUM_CH      = 8,
  parameter int TIME_PERIOD = `STG_TIME_PERIOD,
  parameter int TW          = $clog2(TIME_PERIOD)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [NUM_CH*TW-1:0] load_spike_time,
  input  logic [NUM_CH-1:0]    load_en,
  input  logic                 mode,
  input  logic                 start,
  output logic                 busy,
  output logic [TW-1:0]        time_val,
  output logic [NUM_CH-1:0]    spikes,
  output logic                 period_done
`ifdef SPIKE_COUNT_EN
  ,
  output logic [NUM_CH*$clog2(TIME_PERIOD+1)-1:0] spike_cnt
`endif
);

  localparam logic [TW-1:0] LAST = TW'(TIME_PERIOD - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e                      state_q, state_d;
  logic [TW-1:0]               time_q, time_d;
  logic                        mode_q, mode_d;
  logic [NUM_CH-1:0][TW-1:0]   st_q, st_d;
  logic [NUM_CH-1:0]           en_q, en_d;
  logic [NUM_CH-1:0]           spikes_q, spikes_d;
  logic [NUM_CH-1:0]           spk_cmp;
  logic                        busy_q, done_q, done_d;
  logic                        start_acc;

  assign start_acc = (state_q == IDLE) && start;

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    mode_d  = mode_q;
    st_d    = st_q;
    en_d    = en_q;
    // Loads land on the same edge as a start, so the new period sees them.
    if (load_valid && (state_q == IDLE)) begin
      st_d = load_spike_time;
      en_d = load_en;
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          time_d  = '0;
          mode_d  = mode;
        end
      end
      RUN: begin
        if (time_q == LAST) begin
          state_d = IDLE;
          time_d  = '0;
        end else begin
          time_d  = time_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    done_d   = (state_d == RUN) && (time_d == LAST);
    spikes_d = (state_d == RUN) ? spk_cmp : '0;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    spike_train_generator_lane #(.TW(TW)) u_lane (
      .st_i   (st_d[g]),
      .t_i    (time_d),
      .en_i   (en_d[g]),
      .mode_i (mode_d),
      .spk_o  (spk_cmp[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      time_q   <= '0;
      mode_q   <= 1'b0;
      st_q     <= '0;
      en_q     <= '0;
      spikes_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      time_q   <= time_d;
      mode_q   <= mode_d;
      st_q     <= st_d;
      en_q     <= en_d;
      spikes_q <= spikes_d;
      busy_q   <= (state_d == RUN);
      done_q   <= done_d;
    end
  end

  assign load_ready  = (state_q == IDLE);
  assign busy        = busy_q;
  assign time_val    = time_q;
  assign spikes      = spikes_q;
  assign period_done = done_q;

`ifdef SPIKE_COUNT_EN
  localparam int CW = $clog2(TIME_PERIOD + 1);

  logic [NUM_CH-1:0][CW-1:0] cnt_q;

  // Counts the registered spike bits; spikes are 0 outside RUN, so the value
  // naturally holds after the period. Max is TIME_PERIOD, which fits CW.
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_q[i] + CW'(spikes_q[i]);
      end
    end
  end

  assign spike_cnt = cnt_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_spike_train_generator.sv
// Bench for spike_train_generator with NUM_CH=4, TIME_PERIOD=8.
// Reference model: per-channel spike time/enable/mode arrays; expected spikes
// at each step come straight from the LEVEL/PULSE rules.
module tb_spike_train_generator;
  localparam int NCH = 4;
  localparam int TP  = 8;
  localparam int TW  = 3;
  localparam int CW  = 4;

  logic              clk = 1'b0;
  logic              rst, load_valid, mode, start;
  logic              load_ready, busy, period_done;
  logic [NCH*TW-1:0] load_spike_time;
  logic [NCH-1:0]    load_en, spikes;
  logic [TW-1:0]     time_val;
`ifdef SPIKE_COUNT_EN
  logic [NCH*CW-1:0] spike_cnt;
`endif

  spike_train_generator #(.NUM_CH(NCH), .TIME_PERIOD(TP)) u_dut (
    .clk             (clk),
    .rst             (rst),
    .load_valid      (load_valid),
    .load_ready      (load_ready),
    .load_spike_time (load_spike_time),
    .load_en         (load_en),
    .mode            (mode),
    .start           (start),
    .busy            (busy),
    .time_val        (time_val),
    .spikes          (spikes),
    .period_done     (period_done)
`ifdef SPIKE_COUNT_EN
    ,
    .spike_cnt       (spike_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          m_st[NCH];
  logic [3:0]  m_en;
  logic        m_mode;
  int          m_cnt[NCH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] exp_spk(input int t);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < NCH; i++)
      r[i] = m_en[i] && (m_mode ? (m_st[i] == t) : (m_st[i] > t));
    return r;
  endfunction

  // Drive a load offer (only called while idle) and mirror it in the model.
  task automatic drive_load(input int s0, input int s1, input int s2, input int s3,
                            input logic [3:0] en);
    int s[NCH];
    s = '{s0, s1, s2, s3};
    for (int i = 0; i < NCH; i++) begin
      m_st[i] = s[i];
      load_spike_time[i*TW +: TW] = TW'(s[i]);
    end
    m_en       = en;
    load_en    = en;
    load_valid = 1'b1;
  endtask

  task automatic begin_period(input logic md);
    start = 1'b1;
    mode  = md;
    step();
    start      = 1'b0;
    load_valid = 1'b0;
    m_mode     = md;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_time"}, 32'(time_val), 32'd0);
    chk({tag, "_spikes"}, 32'(spikes), 32'd0);
    chk({tag, "_done"}, 32'(period_done), 32'd0);
    chk({tag, "_ready"}, 32'(load_ready), 32'd1);
  endtask

  // Called #1 after the start edge; ends #1 after the RUN->IDLE edge.
  // noisy: hammer start/load/mode during RUN, none of which may take effect.
  task automatic run_period(input bit noisy);
    logic [3:0] e;
`ifdef SPIKE_COUNT_EN
    logic [NCH*CW-1:0] ec;
`endif
    for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
    for (int t = 0; t < TP; t++) begin
      e = exp_spk(t);
      chk("run_time", 32'(time_val), 32'(t));
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_spikes", 32'(spikes), 32'(e));
      chk("run_done", 32'(period_done), 32'(t == TP - 1));
      chk("run_ready", 32'(load_ready), 32'd0);
`ifdef SPIKE_COUNT_EN
      if (t == 0) chk("cnt_clear", 32'(spike_cnt), 32'd0);
`endif
      for (int i = 0; i < NCH; i++) m_cnt[i] += int'(e[i]);
      if (noisy) begin
        start           = 1'b1;
        load_valid      = 1'b1;
        load_spike_time = NCH*TW'($urandom);
        load_en         = NCH'($urandom);
        mode            = ~m_mode;
      end
      step();
    end
    start      = 1'b0;
    load_valid = 1'b0;
    chk_idle("end");
`ifdef SPIKE_COUNT_EN
    for (int i = 0; i < NCH; i++) ec[i*CW +: CW] = CW'(m_cnt[i]);
    chk("cnt_total", 32'(spike_cnt), 32'(ec));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; load_valid = 1'b0; mode = 1'b0; start = 1'b0;
    load_spike_time = '0; load_en = '0;
    m_en = '0; m_mode = 1'b0;
    for (int i = 0; i < NCH; i++) begin m_st[i] = 0; m_cnt[i] = 0; end
    step(); step();
    chk_idle("reset");
`ifdef SPIKE_COUNT_EN
    chk("reset_cnt", 32'(spike_cnt), 32'd0);
`endif
    rst = 1'b0;
    step();

    // LEVEL {5,0,7,3}, all enabled, separate load cycle.
    drive_load(5, 0, 7, 3, 4'b1111);
    step();
    load_valid = 1'b0;
    begin_period(1'b0);
    run_period(1'b0);
`ifdef SPIKE_COUNT_EN
    step();
    chk("cnt_hold", 32'(spike_cnt), 32'h3705);
`endif

    // PULSE, same times, ch2 disabled; load+start in the same cycle.
    drive_load(5, 0, 7, 3, 4'b1011);
    begin_period(1'b1);
    run_period(1'b0);

    // Load+start random, junk loads/starts during RUN, then back-to-back start.
    drive_load($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 7), 4'($urandom));
    begin_period(1'($urandom));
    run_period(1'b1);
    begin_period(1'b0);
    run_period(1'b0);

    // Reset mid-period: abort, registers cleared, no period_done.
    begin_period(1'b0);
    for (int t = 0; t < 3; t++) begin
      chk("pre_rst_time", 32'(time_val), 32'(t));
      chk("pre_rst_done", 32'(period_done), 32'd0);
      step();
    end
    rst = 1'b1;
    step();
    chk_idle("midrst1");
    step();
    chk_idle("midrst2");
    rst = 1'b0;
    m_en = '0; m_mode = 1'b0;
    for (int i = 0; i < NCH; i++) m_st[i] = 0;
    step();
    chk_idle("post_rst");
    begin_period(1'b0);
    run_period(1'b0);

    // Randomized periods, mixed load styles, mostly back-to-back.
    for (int k = 0; k < 16; k++) begin
      int r;
      r = $urandom_range(0, 2);
      if (r == 0) begin
        drive_load($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 7), 4'($urandom));
        step();
        load_valid = 1'b0;
      end else if (r == 1) begin
        drive_load($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 7), 4'($urandom));
      end
      begin_period(1'($urandom));
      run_period(1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
